// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first over WIDTH bits.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' port).
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               bit_sum;
  logic               bit_maj;
  logic [WIDTH-1:0]   res_shift;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  // Single-bit full adder shared across all bit positions
  assign bit_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_maj   = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign res_shift = (res_q >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1, with cin acting as a borrow-in
  assign b_load     = sub ? ~b : b;
  assign carry_load = cin ^ sub;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_shift;
        carry_d = bit_maj;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = res_shift;
          cout_d  = bit_maj;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;
  localparam time PERIOD = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  time          last_done_t;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #(PERIOD/2) clk = ~clk;

  // Reference: plain integer add (or a - b - cin) with the carry in bit W
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    logic [W-1:0] bb;
    bb = msub ? ~mb : mb;
    return {1'b0, ma} + {1'b0, bb} + (W+1)'(mcin ^ msub);
  endfunction

  // Present a start request at a negedge; accepted at the following posedge
  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                             input logic tcin, input logic tsub);
    start = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Checks W busy cycles with held outputs, then the done cycle; ends in the done cycle
  task automatic check_run(input logic [W-1:0] es, input logic ec, input bit poke, input string nm);
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s run_flags k=%0d busy=%b done=%b want busy=1 done=0", nm, k, busy, done);
      end
      total++;
      if (sum !== prev_sum || cout !== prev_cout) begin
        bad++;
        $display("FAIL %s hold k=%0d sum=%h cout=%b want sum=%h cout=%b", nm, k, sum, cout, prev_sum, prev_cout);
      end
      if (poke && k == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (poke && k == 3) start = 1'b0;
    end
    @(negedge clk);
    last_done_t = $time;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done_flags done=%b busy=%b want done=1 busy=0", nm, done, busy);
    end
    total++;
    if (sum !== es || cout !== ec) begin
      bad++;
      $display("FAIL %s result sum=%h cout=%b want sum=%h cout=%b", nm, sum, cout, es, ec);
    end
    prev_sum = es;
    prev_cout = ec;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                        input logic tsub, input string nm);
    logic [W:0] r;
    r = model(ta, tb_, tcin, tsub);
    drive_start(ta, tb_, tcin, tsub);
    check_run(r[W-1:0], r[W], 1'b0, nm);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    rst = 1'b0;
    prev_sum = '0;
    prev_cout = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1");
    @(negedge clk);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a_c1");
    @(negedge clk);
  endtask

  task automatic test_start_in_run();
    drive_start(8'h12, 8'h34, 1'b0, 1'b0);
    check_run(8'h46, 1'b0, 1'b1, "ignore_start");
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    time t1;
    run_op(8'h11, 8'h22, 1'b0, 1'b0, "b2b_first");
    t1 = last_done_t;
    run_op(8'h80, 8'h80, 1'b0, 1'b0, "b2b_second");
    total++;
    if (last_done_t - t1 !== 9 * PERIOD) begin
      bad++;
      $display("FAIL b2b_spacing got=%0t want=%0t", last_done_t - t1, 9 * PERIOD);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    drive_start(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL async_reset busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;
    prev_cout = 1'b0;
    for (int k = 0; k < int'(W) + 3; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL no_done_after_reset k=%0d done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    run_op(8'h03, 8'h04, 1'b0, 1'b0, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_sub();
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_5_7");
    @(negedge clk);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, "sub_7_5");
    @(negedge clk);
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rc, rs;
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, "random");
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_sub();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that time-multiplexes one full-adder datapath (sum = a^b^cin, cout = majority) across a WIDTH-bit operand pair.
- Processes one bit per clock, LSB first.
- Start/done handshake; result held stable until the next operation completes.
- Used where area matters more than latency; the adder core is the same single-bit function the math/adders library already provides.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1 to 64.

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when not busy
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when a result is published
sum  output  WIDTH  result; updates only on completion
cout  output  1  final carry-out; updates only on completion

Behaviour:
- Interface: one clock, clk. Reset is rst: asynchronous, active-high.
- States:
  - IDLE: waiting for a request.
  - RUN: adding, one bit per clock.
  - DONE: single-cycle state that publishes the result.
- Reset: while rst is high, the state is IDLE. busy, done, sum, cout, the internal shift registers, the carry flop and the bit counter are all 0. This holds when rst is asserted mid-RUN: the operation is abandoned and no done is produced.
- Accept: in IDLE or DONE, start=1 at a rising edge has these effects:
  - a and b load into shift registers.
  - The carry flop loads cin.
  - The counter clears to 0.
  - The state moves to RUN.
- start is ignored in RUN. A start raised in DONE is accepted (back-to-back operation).
- RUN, each edge:
  - The bit sum of a_sr[0], b_sr[0] and carry is shifted into the MSB of the internal result register, which shifts right.
  - The carry flop takes the majority value.
  - a_sr and b_sr shift right.
  - The counter increments.
- RUN exit: the edge that processes bit WIDTH-1 (counter == WIDTH-1) moves the state to DONE. On that same edge:
  - sum takes the completed result register.
  - cout takes the final carry.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - Next state is IDLE, or RUN if start=1.
- busy = 1 exactly in RUN.
- Latency: start is sampled at edge E0. done is high in the cycle after edge E(WIDTH), i.e. the cycle between edges E(WIDTH) and E(WIDTH+1). Throughput is one result per WIDTH+1 cycles.
- sum and cout hold the previous result throughout a new RUN and change only at the completion edge.
- Arithmetic is modulo 2^WIDTH, with cout the true carry out of bit WIDTH-1. Operands are unsigned, with no overflow flag.
- Counter width is $clog2(WIDTH) with a minimum of 1. For WIDTH=1, RUN lasts a single edge.
- Inputs a, b and cin may change freely after acceptance without affecting the result.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - When sub=1, b is inverted as it is loaded.
  - The carry flop is initialised to cin XOR sub, so the result is a - b - cin. cout=1 means no borrow.
  - When sub=0, behaviour is identical to the base block.
- Undefined: no sub port; add only.

Test Plan:
- WIDTH=8, rst pulsed, then start with a=0x00, b=0x00, cin=0 -> busy high for 8 cycles; done pulses one cycle later; sum=0x00, cout=0.
- start with a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then start with a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Check that sum holds 0x00/cout 1 from the first result throughout the second RUN.
- During RUN of a=0x12, b=0x34, raise start with a=0xFF, b=0xFF -> the second start is ignored; result is sum=0x46, cout=0.
- Assert start in the DONE cycle with a=0x80, b=0x80, cin=0 -> accepted with no idle gap; next result is sum=0x00, cout=1, and the done pulses are spaced 9 cycles apart.
- Assert rst 4 cycles into RUN of a=0x0F, b=0x01 -> busy, done, sum and cout go to 0 immediately (asynchronously); no done follows; a subsequent start with a=0x03, b=0x04 gives sum=0x07.
- SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0. Then sub=1, a=0x07, b=0x05, cin=0 -> sum=0x02, cout=1.
